// File: rtl/csr_pkg.sv
// Machine-mode CSR constants: CSR addresses, mstatus and mip bit positions, and the misa value.
// Latency: none (constants and pure functions).
// Backpressure: not applicable.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [31:0] MISA_VAL  = 32'h4000_0100;
  localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

  // MPP is hardwired to M-mode, so it always reads back as 2'b11.
  function automatic logic [31:0] mstatus_word(input logic mie, input logic mpie);
    logic [31:0] w;
    w = 32'h0000_1800;
    w[MSTATUS_MIE]  = mie;
    w[MSTATUS_MPIE] = mpie;
    return w;
  endfunction

  function automatic logic [31:0] mip_word(input logic meip, input logic mtip, input logic msip);
    logic [31:0] w;
    w = '0;
    w[MIP_MEIP] = meip;
    w[MIP_MTIP] = mtip;
    w[MIP_MSIP] = msip;
    return w;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit wrapping counter with per-half writes; used for mcycle/minstret when CSR_COUNTERS_EN is defined.
// Latency: write or increment visible one cycle after the edge.
// Backpressure: none; a half write suppresses that cycle's increment.
module csr_counter64 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic        inc,
  output logic [63:0] count
);

  always_ff @(posedge CLK) begin
    if (RST)        count        <= '0;
    else if (wr_lo) count[31:0]  <= wdata;
    else if (wr_hi) count[63:32] <= wdata;
    else if (inc)   count        <= count + 64'd1;
  end

endmodule

// File: rtl/reg_csr_mmode.sv
// M-mode CSR file with N-source read forwarding and trap/MRET sequencing; CSR_COUNTERS_EN adds mcycle/minstret.
// Latency: RDATA/RVALID combinational from operands captured at the previous edge; updates visible next cycle.
// Backpressure: STALL/MEM_WAIT hold the captured operands; CSR state and mip keep updating.
module reg_csr_mmode
  import csr_pkg::*;
#(
  parameter int          FWD_N     = 2,
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                FLUSH,
  input  logic                STALL,
  input  logic                MEM_WAIT,
  input  logic                TRAP_EN,
  input  logic [31:0]         TRAP_CODE,
  input  logic [31:0]         TRAP_PC,
  input  logic [31:0]         TRAP_VAL,
  input  logic                MRET_EN,
  input  logic                RETIRE,
  input  logic                EXT_INT,
  input  logic                TIMER_INT,
  input  logic                SW_INT,
  output logic [1:0]          TRAP_VEC_MODE,
  output logic [31:0]         TRAP_VEC_BASE,
  output logic [31:0]         MEPC_OUT,
  output logic                INT_ALLOW,
  output logic                INT_PENDING,
  input  logic [11:0]         RADDR,
  output logic                RVALID,
  output logic [31:0]         RDATA,
  input  logic                WREN,
  input  logic [11:0]         WADDR,
  input  logic [31:0]         WDATA,
  input  logic [11:0]         FWD_CSR_ADDR,
  input  logic [FWD_N-1:0]    FWD_EN,
  input  logic [12*FWD_N-1:0] FWD_ADDR,
  input  logic [32*FWD_N-1:0] FWD_DATA
);

  logic [11:0]         cap_raddr, cap_waddr, cap_fwd_csr_addr;
  logic [31:0]         cap_wdata;
  logic                cap_wren;
  logic [FWD_N-1:0]    cap_fwd_en;
  logic [12*FWD_N-1:0] cap_fwd_addr;
  logic [32*FWD_N-1:0] cap_fwd_data;

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic        wr_en;
  logic [31:0] csr_rdata, fwd_dat;
  logic        fwd_hit, fwd_vld;

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      cap_raddr        <= '0;
      cap_waddr        <= '0;
      cap_wdata        <= '0;
      cap_wren         <= 1'b0;
      cap_fwd_csr_addr <= '0;
      cap_fwd_en       <= '0;
      cap_fwd_addr     <= '0;
      cap_fwd_data     <= '0;
    end else if (STALL) begin
      cap_fwd_csr_addr <= '0;
      cap_fwd_en       <= FWD_EN;
      cap_fwd_addr     <= FWD_ADDR;
      cap_fwd_data     <= FWD_DATA;
    end else if (!MEM_WAIT) begin
      cap_raddr        <= RADDR;
      cap_waddr        <= WADDR;
      cap_wdata        <= WDATA;
      cap_wren         <= WREN;
      cap_fwd_csr_addr <= FWD_CSR_ADDR;
      cap_fwd_en       <= FWD_EN;
      cap_fwd_addr     <= FWD_ADDR;
      cap_fwd_data     <= FWD_DATA;
    end
  end

  // Only one architectural update per cycle: trap beats MRET beats a software write.
  assign wr_en = WREN && !TRAP_EN && !MRET_EN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
    end else begin
      mip_q <= mip_word(EXT_INT, TIMER_INT, SW_INT);
      if (TRAP_EN) begin
        mepc_q   <= TRAP_PC & ~32'h3;
        mcause_q <= TRAP_CODE;
        mtval_q  <= TRAP_VAL;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (MRET_EN) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (wr_en) begin
        case (WADDR)
          CSR_MSTATUS: begin
            mst_mie  <= WDATA[MSTATUS_MIE];
            mst_mpie <= WDATA[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= WDATA & MIE_WMASK;
          CSR_MTVEC:    mtvec_q    <= WDATA;
          CSR_MSCRATCH: mscratch_q <= WDATA;
          CSR_MEPC:     mepc_q     <= WDATA & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= WDATA;
          CSR_MTVAL:    mtval_q    <= WDATA;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  csr_counter64 u_mcycle (
    .CLK   (CLK),
    .RST   (RST),
    .wr_lo (wr_en && WADDR == CSR_MCYCLE),
    .wr_hi (wr_en && WADDR == CSR_MCYCLEH),
    .wdata (WDATA),
    .inc   (1'b1),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .CLK   (CLK),
    .RST   (RST),
    .wr_lo (wr_en && WADDR == CSR_MINSTRET),
    .wr_hi (wr_en && WADDR == CSR_MINSTRETH),
    .wdata (WDATA),
    .inc   (RETIRE),
    .count (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = RETIRE;
`endif

  always_comb begin
    csr_rdata = '0;
    case (cap_raddr)
      CSR_MSTATUS:   csr_rdata = mstatus_word(mst_mie, mst_mpie);
      CSR_MISA:      csr_rdata = MISA_VAL;
      CSR_MIE:       csr_rdata = mie_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MIP:       csr_rdata = mip_q;
      CSR_MHARTID:   csr_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
`endif
      default: ;
    endcase
  end

  // Scan from the oldest source down so the youngest matching source wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_vld = 1'b0;
    fwd_dat = '0;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (cap_fwd_addr[i*12 +: 12] == cap_raddr) begin
        fwd_hit = 1'b1;
        fwd_vld = cap_fwd_en[i];
        fwd_dat = cap_fwd_data[i*32 +: 32];
      end
    end
  end

  always_comb begin
    RVALID = 1'b1;
    RDATA  = csr_rdata;
    if (cap_raddr == 12'h000) begin
      RDATA = '0;
    end else if (cap_raddr == cap_fwd_csr_addr) begin
      RVALID = 1'b0;
      RDATA  = '0;
    end else if (fwd_hit) begin
      RVALID = fwd_vld;
      RDATA  = fwd_dat;
    end else if (cap_wren && cap_waddr == cap_raddr) begin
      RDATA = cap_wdata;
    end
  end

  assign TRAP_VEC_MODE = mtvec_q[1:0];
  assign TRAP_VEC_BASE = {mtvec_q[31:2], 2'b00};
  assign MEPC_OUT      = mepc_q;
  assign INT_ALLOW     = mst_mie;
  assign INT_PENDING   = mst_mie && |(mip_q & mie_q);

endmodule

// File: tb/tb_reg_csr_mmode.sv
// Scoreboard bench for reg_csr_mmode: directed scenarios then randomized traffic against a behavioural model.
// The stimulus process predicts post-edge outputs into a queue; a monitor pops and compares each cycle.
module tb_reg_csr_mmode;

  localparam int FWD_N = 2;

  logic                CLK = 1'b0;
  logic                RST, FLUSH, STALL, MEM_WAIT;
  logic                TRAP_EN, MRET_EN, RETIRE;
  logic [31:0]         TRAP_CODE, TRAP_PC, TRAP_VAL;
  logic                EXT_INT, TIMER_INT, SW_INT;
  logic [1:0]          TRAP_VEC_MODE;
  logic [31:0]         TRAP_VEC_BASE, MEPC_OUT;
  logic                INT_ALLOW, INT_PENDING;
  logic [11:0]         RADDR;
  logic                RVALID;
  logic [31:0]         RDATA;
  logic                WREN;
  logic [11:0]         WADDR;
  logic [31:0]         WDATA;
  logic [11:0]         FWD_CSR_ADDR;
  logic [FWD_N-1:0]    FWD_EN;
  logic [12*FWD_N-1:0] FWD_ADDR;
  logic [32*FWD_N-1:0] FWD_DATA;

  always #5 CLK = ~CLK;

  reg_csr_mmode #(.FWD_N(FWD_N), .HART_ID(32'h0000_0005), .MTVEC_RST(32'h0000_0203)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL), .MEM_WAIT(MEM_WAIT),
    .TRAP_EN(TRAP_EN), .TRAP_CODE(TRAP_CODE), .TRAP_PC(TRAP_PC), .TRAP_VAL(TRAP_VAL),
    .MRET_EN(MRET_EN), .RETIRE(RETIRE),
    .EXT_INT(EXT_INT), .TIMER_INT(TIMER_INT), .SW_INT(SW_INT),
    .TRAP_VEC_MODE(TRAP_VEC_MODE), .TRAP_VEC_BASE(TRAP_VEC_BASE), .MEPC_OUT(MEPC_OUT),
    .INT_ALLOW(INT_ALLOW), .INT_PENDING(INT_PENDING),
    .RADDR(RADDR), .RVALID(RVALID), .RDATA(RDATA),
    .WREN(WREN), .WADDR(WADDR), .WDATA(WDATA),
    .FWD_CSR_ADDR(FWD_CSR_ADDR), .FWD_EN(FWD_EN), .FWD_ADDR(FWD_ADDR), .FWD_DATA(FWD_DATA)
  );

  typedef struct packed {
    logic        rvalid;
    logic        rdata_chk;
    logic [31:0] rdata;
    logic        int_allow;
    logic        int_pend;
    logic [31:0] mepc;
    logic [1:0]  mode;
    logic [31:0] base;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state: architectural CSRs plus the operands the read port last latched.
  logic        m_mie, m_mpie;
  logic [31:0] m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
  logic [63:0] m_cyc, m_ret;
  logic [11:0] c_raddr, c_waddr, c_fcsr;
  logic [31:0] c_wdata;
  logic        c_wren;
  logic        c_fen   [FWD_N];
  logic [11:0] c_faddr [FWD_N];
  logic [31:0] c_fdata [FWD_N];

  logic [11:0] addr_tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] m_csr(input logic [11:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      12'h300: v = 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mie_r;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = m_mip;
      12'hF14: v = 32'h5;
`ifdef CSR_COUNTERS_EN
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ret[31:0];
      12'hB82: v = m_ret[63:32];
`endif
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  // Apply the current inputs to the model as the coming clock edge will, then queue the expected outputs.
  task automatic model_step();
    exp_t e;
    logic we, hit;
    if (RST) begin
      m_mie = 0; m_mpie = 0; m_mie_r = 0; m_mtvec = 32'h203; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0; m_cyc = 0; m_ret = 0;
    end else begin
      we = WREN && !TRAP_EN && !MRET_EN;
      if (TRAP_EN) begin
        m_mepc = TRAP_PC - (TRAP_PC % 4);
        m_mcause = TRAP_CODE;
        m_mtval = TRAP_VAL;
        m_mpie = m_mie;
        m_mie = 0;
      end else if (MRET_EN) begin
        m_mie = m_mpie;
        m_mpie = 1;
      end else if (we) begin
        case (WADDR)
          12'h300: begin m_mie = WDATA[3]; m_mpie = WDATA[7]; end
          12'h304: m_mie_r = {20'b0, WDATA[11], 3'b0, WDATA[7], 3'b0, WDATA[3], 3'b0};
          12'h305: m_mtvec = WDATA;
          12'h340: m_mscratch = WDATA;
          12'h341: m_mepc = WDATA - (WDATA % 4);
          12'h342: m_mcause = WDATA;
          12'h343: m_mtval = WDATA;
          default: ;
        endcase
      end
      if (we && WADDR == 12'hB00)      m_cyc[31:0]  = WDATA;
      else if (we && WADDR == 12'hB80) m_cyc[63:32] = WDATA;
      else                             m_cyc        = m_cyc + 1;
      if (we && WADDR == 12'hB02)      m_ret[31:0]  = WDATA;
      else if (we && WADDR == 12'hB82) m_ret[63:32] = WDATA;
      else if (RETIRE)                 m_ret        = m_ret + 1;
      m_mip = {20'b0, EXT_INT, 3'b0, TIMER_INT, 3'b0, SW_INT, 3'b0};
    end
    if (RST || FLUSH) begin
      c_raddr = 0; c_waddr = 0; c_wdata = 0; c_wren = 0; c_fcsr = 0;
      for (int i = 0; i < FWD_N; i++) begin c_fen[i] = 0; c_faddr[i] = 0; c_fdata[i] = 0; end
    end else if (STALL || !MEM_WAIT) begin
      if (STALL) c_fcsr = 0;
      else begin
        c_raddr = RADDR; c_waddr = WADDR; c_wdata = WDATA; c_wren = WREN; c_fcsr = FWD_CSR_ADDR;
      end
      for (int i = 0; i < FWD_N; i++) begin
        c_fen[i] = FWD_EN[i]; c_faddr[i] = FWD_ADDR[12*i +: 12]; c_fdata[i] = FWD_DATA[32*i +: 32];
      end
    end
    e.rvalid = 1; e.rdata_chk = 1; e.rdata = 0;
    hit = 0;
    if (c_raddr == 0) e.rdata = 0;
    else if (c_raddr == c_fcsr) begin e.rvalid = 0; e.rdata_chk = 0; end
    else begin
      for (int i = 0; i < FWD_N; i++)
        if (!hit && c_faddr[i] == c_raddr) begin
          hit = 1; e.rvalid = c_fen[i]; e.rdata = c_fdata[i];
        end
      if (!hit) e.rdata = (c_wren && c_waddr == c_raddr) ? c_wdata : m_csr(c_raddr);
    end
    e.int_allow = m_mie;
    e.int_pend  = m_mie && ((m_mip & m_mie_r) != 0);
    e.mepc      = m_mepc;
    e.mode      = m_mtvec[1:0];
    e.base      = {m_mtvec[31:2], 2'b00};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    RST = 0; FLUSH = 0; STALL = 0; MEM_WAIT = 0; TRAP_EN = 0; MRET_EN = 0; RETIRE = 0;
    TRAP_CODE = 0; TRAP_PC = 0; TRAP_VAL = 0; EXT_INT = 0; TIMER_INT = 0; SW_INT = 0;
    RADDR = 0; WREN = 0; WADDR = 0; WDATA = 0; FWD_CSR_ADDR = 0; FWD_EN = 0; FWD_ADDR = 0; FWD_DATA = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    idle(); WREN = 1; WADDR = a; WDATA = d; tick();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rvalid", 32'(RVALID), 32'(e.rvalid));
        if (e.rdata_chk) chk("rdata", RDATA, e.rdata);
        chk("int_allow", 32'(INT_ALLOW), 32'(e.int_allow));
        chk("int_pending", 32'(INT_PENDING), 32'(e.int_pend));
        chk("mepc_out", MEPC_OUT, e.mepc);
        chk("vec_mode", 32'(TRAP_VEC_MODE), 32'(e.mode));
        chk("vec_base", TRAP_VEC_BASE, e.base);
      end
    end
  end

  initial begin
    addr_tbl = '{12'h000, 12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                 12'h343, 12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123};
    idle(); RST = 1; tick(); tick();
    chk("reset_rvalid", 32'(RVALID), 32'h1);
    chk("reset_rdata", RDATA, 32'h0);
    chk("reset_mode", 32'(TRAP_VEC_MODE), 32'h3);

    wr(12'h305, 32'h8000_0101);
    idle(); RADDR = 12'h305; tick();
    chk("mtvec_read", RDATA, 32'h8000_0101);
    chk("mtvec_mode", 32'(TRAP_VEC_MODE), 32'h1);
    chk("mtvec_base", TRAP_VEC_BASE, 32'h8000_0100);

    wr(12'h300, 32'h8);
    idle(); TRAP_EN = 1; TRAP_PC = 32'h1002; TRAP_CODE = 32'd11; TRAP_VAL = 32'h55; RADDR = 12'h342; tick();
    chk("trap_mepc", MEPC_OUT, 32'h1000);
    chk("trap_mcause", RDATA, 32'd11);
    chk("trap_mie", 32'(INT_ALLOW), 32'h0);
    idle(); RADDR = 12'h300; tick();
    chk("trap_mstatus", RDATA, 32'h1880);
    idle(); MRET_EN = 1; RADDR = 12'h300; tick();
    chk("mret_mstatus", RDATA, 32'h1888);
    chk("mret_mie", 32'(INT_ALLOW), 32'h1);

    idle(); FWD_EN = 2'b11; FWD_ADDR = {12'h340, 12'h340}; FWD_DATA = {32'hBBBB_0002, 32'hAAAA_0001};
    RADDR = 12'h340; tick();
    chk("fwd_youngest", RDATA, 32'hAAAA_0001);
    FWD_CSR_ADDR = 12'h340; tick();
    chk("fwd_csr_pending", 32'(RVALID), 32'h0);

    wr(12'h304, 32'h80);
    chk("int_idle", 32'(INT_PENDING), 32'h0);
    idle(); TIMER_INT = 1; RADDR = 12'h344; tick();
    chk("int_pending", 32'(INT_PENDING), 32'h1);
    chk("mip_read", RDATA, 32'h80);

`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 32'hFFFF_FFFF);
    idle(); WREN = 1; WADDR = 12'hB80; WDATA = 32'h0; RADDR = 12'hB00; tick();
    chk("mcycle_hold", RDATA, 32'hFFFF_FFFF);
    idle(); RADDR = 12'hB80; tick();
    chk("mcycleh_carry", RDATA, 32'h1);
`else
    wr(12'hB00, 32'h1234);
    idle(); RADDR = 12'hB00; tick();
    chk("mcycle_absent", RDATA, 32'h0);
`endif

    wr(12'h340, 32'hCAFE_0000);
    idle(); MEM_WAIT = 1; RADDR = 12'h340; tick();
    RST = 1; tick();
    chk("rst_memwait_rdata", RDATA, 32'h0);
    chk("rst_memwait_rvalid", 32'(RVALID), 32'h1);
    chk("rst_memwait_mepc", MEPC_OUT, 32'h0);
    chk("rst_memwait_mie", 32'(INT_ALLOW), 32'h0);
    chk("rst_memwait_base", TRAP_VEC_BASE, 32'h200);

    for (int n = 0; n < 3000; n++) begin
      RST          = ($urandom_range(0, 199) == 0);
      FLUSH        = ($urandom_range(0, 19) == 0);
      STALL        = ($urandom_range(0, 7) == 0);
      MEM_WAIT     = ($urandom_range(0, 7) == 0);
      TRAP_EN      = ($urandom_range(0, 15) == 0);
      MRET_EN      = ($urandom_range(0, 15) == 0);
      RETIRE       = 1'($urandom_range(0, 1));
      TRAP_CODE    = $urandom;
      TRAP_PC      = $urandom;
      TRAP_VAL     = $urandom;
      EXT_INT      = 1'($urandom_range(0, 1));
      TIMER_INT    = 1'($urandom_range(0, 1));
      SW_INT       = 1'($urandom_range(0, 1));
      RADDR        = addr_tbl[$urandom_range(0, 15)];
      WREN         = ($urandom_range(0, 2) == 0);
      WADDR        = addr_tbl[$urandom_range(0, 15)];
      WDATA        = $urandom;
      FWD_CSR_ADDR = ($urandom_range(0, 3) == 0) ? addr_tbl[$urandom_range(0, 15)] : 12'h000;
      FWD_EN       = 2'($urandom_range(0, 3));
      FWD_ADDR     = {addr_tbl[$urandom_range(0, 15)], addr_tbl[$urandom_range(0, 15)]};
      FWD_DATA     = {$urandom, $urandom};
      tick();
    end

    idle(); tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
